barcode_serializer: RTL and testbench
=====================================

// Module: barcode_serializer
// PURPOSE
//   Downstream stage of the ticket selector: consumes the 6-bit ticket code
//   (client + duration selection) and serialises it into a timed bar/space
//   stream that drives the barcode printer head.
//   Frame = start guard, Manchester-coded data bits MSB first, even parity
//   bit, stop guard, then a quiet zone. One frame per accepted code.
// PARAMETERS
//   CODE_WIDTH     6  ticket code width in bits
//   MODULE_CYCLES  4  clock cycles per bar/space module (>=1)
//   QUIET_MODULES  2  all-space modules after stop guard (>=1)
// PORTS
//   Clk        in   1           system clock, rising edge
//   Reset_n    in   1           asynchronous reset, active low
//   Code       in   CODE_WIDTH  ticket code from selector
//   CodeValid  in   1           Code is valid
//   CodeReady  out  1           block can accept a code
//   Bar        out  1           1 = bar (print), 0 = space
//   BarValid   out  1           Bar is part of a frame
//   Busy       out  1           frame or quiet zone in progress
//   Done       out  1           1-cycle pulse at frame end
// BEHAVIOUR
//   Reset (async, Reset_n=0): state IDLE, Bar=0, BarValid=0, Busy=0, Done=0,
//     CodeReady=1 once Reset_n released; all counters cleared.
//   All outputs registered.
//   Handshake: accept on rising edge with CodeValid=1 && CodeReady=1; Code
//     captured into internal register; parity = XOR of captured bits (even
//     parity: parity bit makes total ones even). Code changes after accept
//     ignored. CodeValid while CodeReady=0 ignored (no queueing).
//   States: IDLE -> START -> DATA -> PARITY -> STOP -> QUIET -> IDLE.
//     IDLE:   CodeReady=1, Busy=0, BarValid=0.
//     START:  modules 1,0,1.
//     DATA:   per bit, MSB first: bit 1 -> modules 1,0; bit 0 -> 0,1.
//     PARITY: same encoding as a data bit.
//     STOP:   modules 1,0,1.
//     QUIET:  QUIET_MODULES modules Bar=0, BarValid=0, Busy=1.
//   Each module lasts exactly MODULE_CYCLES cycles; cycle counter wraps
//     MODULE_CYCLES-1 -> 0 and advances module index; index wraps per state.
//   Frame modules = 3 + 2*(CODE_WIDTH+1) + 3 = 20 at default.
//   Timing (edge 0 = accept edge): cycles 1..20*MODULE_CYCLES: BarValid=1,
//     Busy=1, CodeReady=0; first START module on cycle 1 (latency 1).
//     Done=1 only on first QUIET cycle (cycle 20*MC+1).
//     CodeReady=1 on cycle (20+QUIET_MODULES)*MC+1; a code may be accepted
//     on that same edge (back-to-back frames, no extra gap).
//   MODULE_CYCLES=1: one module per cycle, no skipped/duplicated modules.
//   Reset mid-frame: outputs to reset values immediately, partial frame
//     abandoned, no Done pulse.
// TESTING
//   1 Reset_n=0 mid-run -> Bar=0,BarValid=0,Busy=0,Done=0 same cycle;
//     release -> CodeReady=1.
//   2 Code=6'b101100 accepted, MC=4 -> modules 101 10 01 10 10 01 01 10 101,
//     each held 4 cycles, BarValid cycles 1..80, Done at 81, CodeReady at 89.
//   3 Code=6'b000000 -> data 01x6, parity bit 0 -> 01; Code=6'b111111 ->
//     parity bit 0 -> 01; Code=6'b000001 -> parity bit 1 -> 10.
//   4 CodeValid=1 held with new Code during frame -> ignored, frame bits
//     unchanged; new code accepted exactly on the CodeReady=1 edge, next
//     frame starts the following cycle.
//   5 MODULE_CYCLES=1, QUIET_MODULES=1 -> 20 BarValid cycles, Done at 21,
//     CodeReady at 22.
//   6 Reset_n pulsed at cycle 30 of a frame -> no Done, new code accepted
//     after release produces a complete correct frame.

Source files
------------

// File: rtl/barcode_serializer.sv
// Serialises an accepted ticket code into a timed bar/space frame for the printer head:
// start guard, Manchester data bits MSB first, even parity bit, stop guard, then a quiet zone.
module barcode_serializer #(
    parameter int unsigned CODE_WIDTH    = 6,
    parameter int unsigned MODULE_CYCLES = 4,
    parameter int unsigned QUIET_MODULES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [CODE_WIDTH-1:0] Code,
    input  logic                  CodeValid,
    output logic                  CodeReady,
    output logic                  Bar,
    output logic                  BarValid,
    output logic                  Busy,
    output logic                  Done
);

    localparam int unsigned CYC_W   = (MODULE_CYCLES > 1) ? $clog2(MODULE_CYCLES) : 1;
    localparam int unsigned MAX_MOD = (QUIET_MODULES > 3) ? QUIET_MODULES : 3;
    localparam int unsigned MOD_W   = $clog2(MAX_MOD);
    localparam int unsigned BIT_W   = (CODE_WIDTH > 1) ? $clog2(CODE_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_QUIET  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [MOD_W-1:0]      mod_q, mod_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [CODE_WIDTH-1:0] code_q, code_d;

    logic accept;
    logic mod_last;
    logic bar_d, bar_valid_d, busy_d, done_d, ready_d;

    assign accept = CodeValid & CodeReady;

    // State, position counters, captured code and registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            mod_q     <= '0;
            bit_q     <= '0;
            code_q    <= '0;
            Bar       <= 1'b0;
            BarValid  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            CodeReady <= 1'b1;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            mod_q     <= mod_d;
            bit_q     <= bit_d;
            code_q    <= code_d;
            Bar       <= bar_d;
            BarValid  <= bar_valid_d;
            Busy      <= busy_d;
            Done      <= done_d;
            CodeReady <= ready_d;
        end
    end

    // Next position: cycle counter inside a module, module index inside a state
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        mod_d    = mod_q;
        bit_d    = bit_q;
        code_d   = code_q;
        mod_last = 1'b1;

        unique case (state_q)
            S_START, S_STOP:  mod_last = (mod_q == MOD_W'(2));
            S_DATA, S_PARITY: mod_last = (mod_q == MOD_W'(1));
            S_QUIET:          mod_last = (mod_q == MOD_W'(QUIET_MODULES - 1));
            default:          mod_last = 1'b1;
        endcase

        if (state_q == S_IDLE) begin
            if (accept) begin
                state_d = S_START;
                cyc_d   = '0;
                mod_d   = '0;
                code_d  = Code;
            end
        end else if (cyc_q == CYC_W'(MODULE_CYCLES - 1)) begin
            cyc_d = '0;
            if (!mod_last) begin
                mod_d = mod_q + MOD_W'(1);
            end else begin
                mod_d = '0;
                unique case (state_q)
                    S_START: begin
                        state_d = S_DATA;
                        bit_d   = BIT_W'(CODE_WIDTH - 1);
                    end
                    S_DATA: begin
                        if (bit_q == '0) state_d = S_PARITY;
                        else             bit_d   = bit_q - BIT_W'(1);
                    end
                    S_PARITY: state_d = S_STOP;
                    S_STOP:   state_d = S_QUIET;
                    default:  state_d = S_IDLE;
                endcase
            end
        end else begin
            cyc_d = cyc_q + CYC_W'(1);
        end
    end

    // Output D values follow the next position so the frame starts one cycle after accept
    always_comb begin
        bar_d       = 1'b0;
        bar_valid_d = 1'b0;
        busy_d      = (state_d != S_IDLE);
        ready_d     = (state_d == S_IDLE);
        done_d      = (state_d == S_QUIET) && (state_q != S_QUIET);

        unique case (state_d)
            S_START, S_STOP: begin
                bar_d       = (mod_d != MOD_W'(1));
                bar_valid_d = 1'b1;
            end
            S_DATA: begin
                bar_d       = (mod_d == '0) ? code_q[bit_d] : ~code_q[bit_d];
                bar_valid_d = 1'b1;
            end
            S_PARITY: begin
                bar_d       = (mod_d == '0) ? ^code_q : ~(^code_q);
                bar_valid_d = 1'b1;
            end
            default: begin
                bar_d       = 1'b0;
                bar_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_barcode_serializer.sv
// Bench for barcode_serializer: default timing (MC=4,Q=2) and fast timing (MC=1,Q=1)
// instances checked cycle by cycle against a frame model built from the code value.
module tb_barcode_serializer;

    logic       clk;
    logic       rst_n;
    logic [5:0] code0, code1;
    logic       valid0, valid1;
    logic       ready0, bar0, bv0, busy0, done0;
    logic       ready1, bar1, bv1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;
    int sel_v    = 0;

    logic o_ready, o_bar, o_bv, o_busy, o_done;
    assign o_ready = (sel_v != 0) ? ready1 : ready0;
    assign o_bar   = (sel_v != 0) ? bar1   : bar0;
    assign o_bv    = (sel_v != 0) ? bv1    : bv0;
    assign o_busy  = (sel_v != 0) ? busy1  : busy0;
    assign o_done  = (sel_v != 0) ? done1  : done0;

    barcode_serializer dut0 (
        .Clk(clk), .Reset_n(rst_n), .Code(code0), .CodeValid(valid0),
        .CodeReady(ready0), .Bar(bar0), .BarValid(bv0), .Busy(busy0), .Done(done0)
    );

    barcode_serializer #(.CODE_WIDTH(6), .MODULE_CYCLES(1), .QUIET_MODULES(1)) dut1 (
        .Clk(clk), .Reset_n(rst_n), .Code(code1), .CodeValid(valid1),
        .CodeReady(ready1), .Bar(bar1), .BarValid(bv1), .Busy(busy1), .Done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic [5:0] c, input logic v);
        if (sel != 0) begin code1 = c; valid1 = v; end
        else          begin code0 = c; valid0 = v; end
    endtask

    // Runs one frame starting just after a negedge; abort_at>0 resets mid-frame at that cycle.
    task automatic run_frame(input int sel, input logic [5:0] c, input bit hold,
                             input logic [5:0] nxt, input int abort_at);
        int mc, q, nb, tot;
        bit mods[20];
        bit p;
        logic e_bar, e_bv, e_busy, e_done, e_ready;
        mc  = (sel != 0) ? 1 : 4;
        q   = (sel != 0) ? 1 : 2;
        nb  = 20 * mc;
        tot = (20 + q) * mc + 1;
        p   = ^c;
        mods[0] = 1; mods[1] = 0; mods[2] = 1;
        for (int i = 0; i < 6; i++) begin
            mods[3 + 2*i] = c[5 - i];
            mods[4 + 2*i] = !c[5 - i];
        end
        mods[15] = p; mods[16] = !p;
        mods[17] = 1; mods[18] = 0; mods[19] = 1;

        sel_v = sel;
        set_in(sel, c, 1'b1);
        chk($sformatf("ready_pre s%0d", sel), 32'(o_ready), 32'(1));
        @(posedge clk);
        for (int cyc = 1; cyc <= tot; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                if (hold) set_in(sel, nxt, 1'b1);
                else      set_in(sel, 6'($urandom), 1'b0);
            end
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_bar",  32'(o_bar),  32'(0));
                chk("rst_bv",   32'(o_bv),   32'(0));
                chk("rst_busy", 32'(o_busy), 32'(0));
                chk("rst_done", 32'(o_done), 32'(0));
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("post_rst_done",  32'(o_done),  32'(0));
                    chk("post_rst_busy",  32'(o_busy),  32'(0));
                    chk("post_rst_ready", 32'(o_ready), 32'(1));
                end
                return;
            end
            if (cyc <= nb) begin
                e_bar = mods[(cyc - 1) / mc]; e_bv = 1; e_busy = 1; e_done = 0; e_ready = 0;
            end else if (cyc < tot) begin
                e_bar = 0; e_bv = 0; e_busy = 1; e_done = (cyc == nb + 1); e_ready = 0;
            end else begin
                e_bar = 0; e_bv = 0; e_busy = 0; e_done = 0; e_ready = 1;
            end
            chk($sformatf("bar s%0d code%b c%0d", sel, c, cyc),   32'(o_bar),   32'(e_bar));
            chk($sformatf("bv s%0d code%b c%0d", sel, c, cyc),    32'(o_bv),    32'(e_bv));
            chk($sformatf("busy s%0d code%b c%0d", sel, c, cyc),  32'(o_busy),  32'(e_busy));
            chk($sformatf("done s%0d code%b c%0d", sel, c, cyc),  32'(o_done),  32'(e_done));
            chk($sformatf("ready s%0d code%b c%0d", sel, c, cyc), 32'(o_ready), 32'(e_ready));
        end
    endtask

    initial begin
        logic [5:0] r, r2;
        rst_n = 1'b0;
        code0 = '0; code1 = '0; valid0 = 1'b0; valid1 = 1'b0;
        #3;
        chk("init_bar0",  32'(bar0),  32'(0));
        chk("init_bv0",   32'(bv0),   32'(0));
        chk("init_busy0", 32'(busy0), 32'(0));
        chk("init_done0", 32'(done0), 32'(0));
        chk("init_busy1", 32'(busy1), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready0", 32'(ready0), 32'(1));
        chk("rel_ready1", 32'(ready1), 32'(1));

        // Directed frames on the default-timing instance
        run_frame(0, 6'b101100, 0, 6'b0, 0);
        run_frame(0, 6'b000000, 0, 6'b0, 0);
        run_frame(0, 6'b111111, 0, 6'b0, 0);
        r = 6'($urandom);
        run_frame(0, 6'b000001, 1, r, 0);
        run_frame(0, r, 0, 6'b0, 0);

        // Mid-frame reset, then a clean frame
        r = 6'($urandom);
        run_frame(0, r, 0, 6'b0, 30);
        r = 6'($urandom);
        run_frame(0, r, 0, 6'b0, 0);

        for (int i = 0; i < 3; i++) begin
            r  = 6'($urandom);
            r2 = 6'($urandom);
            run_frame(0, r, (i == 1), r2, 0);
            if (i == 1) run_frame(0, r2, 0, 6'b0, 0);
        end

        // Single-cycle modules, single quiet module
        run_frame(1, 6'b101100, 0, 6'b0, 0);
        r = 6'($urandom);
        run_frame(1, 6'b000001, 1, r, 0);
        run_frame(1, r, 0, 6'b0, 0);
        for (int i = 0; i < 4; i++) begin
            r = 6'($urandom);
            run_frame(1, r, 0, 6'b0, 0);
        end
        r = 6'($urandom);
        run_frame(1, r, 0, 6'b0, 7);
        r = 6'($urandom);
        run_frame(1, r, 0, 6'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
